// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the single-clock programmable FIFO.
package sync_fifo_pkg;

  localparam string FT_TRUE  = "TRUE";
  localparam string FT_FALSE = "FALSE";

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  function automatic bit level_in_range(input int lvl, input int lo, input int hi);
    return (lvl >= lo) && (lvl <= hi);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: write-clocked RAM with either a combinational (fall-through)
// or a registered read port.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int    DSIZE       = 8,
  parameter int    ASIZE       = 4,
  parameter string FALLTHROUGH = "FALSE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_r [DEPTH];

  // RAM write port; no reset so the array maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  if (FALLTHROUGH == FT_TRUE) begin : g_fwft
    assign rdata = mem_r[raddr];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_r;

    // Registered read port: loads only on an accepted pop, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_r <= '0;
      end else if (re) begin
        rdata_r <= mem_r[raddr];
      end else begin
        rdata_r <= rdata_r;
      end
    end

    assign rdata = rdata_r;
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int    DSIZE        = 8,
  parameter int    ASIZE        = 4,
  parameter string FALLTHROUGH  = "FALSE",
  parameter int    AFULL_LEVEL  = int'(fifo_depth(ASIZE)) - 32'sd1,
  parameter int    AEMPTY_LEVEL = 32'sd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    DEPTH    = fifo_depth(ASIZE);
  localparam logic [ASIZE:0] DEPTH_L  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_L  = (ASIZE+1)'(AFULL_LEVEL);
  localparam logic [ASIZE:0] AEMPTY_L = (ASIZE+1)'(AEMPTY_LEVEL);
  localparam logic [ASIZE:0] ONE_L    = {{ASIZE{1'b0}}, 1'b1};

  if (!((FALLTHROUGH == FT_TRUE) || (FALLTHROUGH == FT_FALSE))) begin : g_bad_ft
    $error("sync_fifo_prog: FALLTHROUGH must be \"TRUE\" or \"FALSE\"");
  end
  if (!level_in_range(AFULL_LEVEL, 32'sd1, int'(DEPTH))) begin : g_bad_afull
    $error("sync_fifo_prog: AFULL_LEVEL must lie in 1..DEPTH");
  end
  if (!level_in_range(AEMPTY_LEVEL, 32'sd0, int'(DEPTH) - 32'sd1)) begin : g_bad_aempty
    $error("sync_fifo_prog: AEMPTY_LEVEL must lie in 0..DEPTH-1");
  end

  logic [ASIZE:0] wptr_r, rptr_r, level_r;
  logic [ASIZE:0] wptr_next_s, rptr_next_s, level_next_s;
  logic           wr_acc_s, rd_acc_s;
  logic           wfull_r, awfull_r, rempty_r, arempty_r;
  logic           overflow_r, underflow_r;

  // Accept decisions and next pointers; flush overrides both requests.
  always_comb begin
    wr_acc_s    = 1'b0;
    rd_acc_s    = 1'b0;
    wptr_next_s = wptr_r;
    rptr_next_s = rptr_r;
    if (flush) begin
      wptr_next_s = '0;
      rptr_next_s = '0;
    end else begin
      wr_acc_s = winc && !wfull_r;
      rd_acc_s = rinc && !rempty_r;
      if (wr_acc_s) begin
        wptr_next_s = wptr_r + ONE_L;
      end else begin
        wptr_next_s = wptr_r;
      end
      if (rd_acc_s) begin
        rptr_next_s = rptr_r + ONE_L;
      end else begin
        rptr_next_s = rptr_r;
      end
    end
    level_next_s = wptr_next_s - rptr_next_s;
  end

  // Pointers, level and status flags; flags are registered from the next
  // level so they always equal a decode of the level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      level_r   <= '0;
      wfull_r   <= 1'b0;
      awfull_r  <= 1'b0;
      rempty_r  <= 1'b1;
      arempty_r <= 1'b1;
    end else begin
      wptr_r    <= wptr_next_s;
      rptr_r    <= rptr_next_s;
      level_r   <= level_next_s;
      wfull_r   <= (level_next_s == DEPTH_L);
      awfull_r  <= (level_next_s >= AFULL_L);
      rempty_r  <= (level_next_s == '0);
      arempty_r <= (level_next_s <= AEMPTY_L);
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (winc && wfull_r);
      underflow_r <= underflow_r | (rinc && rempty_r);
    end
  end

  sync_fifo_ram #(
    .DSIZE       (DSIZE),
    .ASIZE       (ASIZE),
    .FALLTHROUGH (FALLTHROUGH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc_s),
    .waddr (wptr_r[ASIZE-1:0]),
    .wdata (wdata),
    .re    (rd_acc_s),
    .raddr (rptr_r[ASIZE-1:0]),
    .rdata (rdata)
  );

  assign wfull     = wfull_r;
  assign awfull    = awfull_r;
  assign rempty    = rempty_r;
  assign arempty   = arempty_r;
  assign level     = level_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: one registered-read and one fall-through FIFO share the
// same stimulus and are checked against a queue model.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n, flush, winc, rinc;
  logic [7:0] wdata;

  logic       r_wfull, r_awfull, r_rempty, r_arempty, r_ovf, r_unf;
  logic [7:0] r_rdata;
  logic [4:0] r_level;
  logic       f_wfull, f_awfull, f_rempty, f_arempty, f_ovf, f_unf;
  logic [7:0] f_rdata;
  logic [4:0] f_level;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] reg_rd;
  logic       mdl_ovf, mdl_unf;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE"), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(r_wfull), .awfull(r_awfull), .rinc(rinc), .rdata(r_rdata),
    .rempty(r_rempty), .arempty(r_arempty), .level(r_level),
    .overflow(r_ovf), .underflow(r_unf));

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE"), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut_ft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(f_wfull), .awfull(f_awfull), .rinc(rinc), .rdata(f_rdata),
    .rempty(f_rempty), .arempty(f_arempty), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf));

  // One clock of stimulus, called at a falling edge; the model and the data
  // scoreboard advance here, and level/error flags are compared every cycle.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    logic       wa, ra;
    logic [7:0] exp;
    winc = w; wdata = d; rinc = r; flush = f;
    wa = w && !f && (q.size() < 16);
    ra = r && !f && (q.size() > 0);
    exp = 8'h00;
    #1;
    if (ra) begin
      exp = q.pop_front();
      checks++;
      if (f_rdata !== exp) begin
        errors++; $display("FAIL fwft_rdata: got %h expected %h", f_rdata, exp);
      end
      reg_rd = exp;
    end
    if (wa) q.push_back(d);
    if (f) begin
      q.delete(); mdl_ovf = 1'b0; mdl_unf = 1'b0;
    end else begin
      if (w && !wa) mdl_ovf = 1'b1;
      if (r && !ra) mdl_unf = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (r_rdata !== reg_rd) begin
      errors++; $display("FAIL reg_rdata: got %h expected %h", r_rdata, reg_rd);
    end
    checks++;
    if ({r_level, f_level} !== {5'(q.size()), 5'(q.size())}) begin
      errors++; $display("FAIL level: got reg %0d ft %0d expected %0d", r_level, f_level, q.size());
    end
    checks++;
    if ({r_ovf, r_unf, f_ovf, f_unf} !== {mdl_ovf, mdl_unf, mdl_ovf, mdl_unf}) begin
      errors++; $display("FAIL err_flags: got %b%b %b%b expected %b%b", r_ovf, r_unf, f_ovf, f_unf, mdl_ovf, mdl_unf);
    end
    winc = 1'b0; rinc = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    reg_rd = 8'h00; mdl_ovf = 1'b0; mdl_unf = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({r_wfull, r_awfull, r_arempty, r_rempty, f_wfull, f_awfull, f_arempty, f_rempty} !== 8'b0011_0011) begin
      errors++; $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b expected 0011 0011",
                         r_wfull, r_awfull, r_arempty, r_rempty, f_wfull, f_awfull, f_arempty, f_rempty);
    end
    checks++;
    if ({r_level, f_level, r_ovf, r_unf, f_ovf, f_unf, r_rdata} !== 22'd0) begin
      errors++; $display("FAIL reset_state: level %0d/%0d err %b%b%b%b rdata %h expected all 0",
                         r_level, f_level, r_ovf, r_unf, f_ovf, f_unf, r_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [3:0] exp_fl;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      exp_fl = {(i + 1) == 16, (i + 1) >= 14, (i + 1) <= 2, 1'b0};
      checks++;
      if ({r_wfull, r_awfull, r_arempty, r_rempty, f_wfull, f_awfull, f_arempty, f_rempty} !== {exp_fl, exp_fl}) begin
        errors++; $display("FAIL fill_flags L=%0d: got %b%b%b%b %b%b%b%b expected %b", i + 1,
                           r_wfull, r_awfull, r_arempty, r_rempty, f_wfull, f_awfull, f_arempty, f_rempty, exp_fl);
      end
    end
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({r_rempty, f_rempty, r_arempty} !== 3'b111) begin
      errors++; $display("FAIL drain_empty: got %b%b%b expected 111", r_rempty, f_rempty, r_arempty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if ({r_level, r_ovf, f_level, f_ovf, r_wfull} !== {5'd16, 1'b1, 5'd16, 1'b1, 1'b1}) begin
      errors++; $display("FAIL overflow: got level %0d ovf %b wfull %b expected 16 1 1", r_level, r_ovf, r_wfull);
    end
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    checks++;
    if ({r_level, f_level, r_wfull} !== {5'd15, 5'd15, 1'b0}) begin
      errors++; $display("FAIL push_pop_full: got level %0d wfull %b expected 15 0", r_level, r_wfull);
    end
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    checks++;
    if ({r_level, r_ovf, r_unf, r_rempty, f_rempty} !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL flush: got level %0d ovf %b unf %b rempty %b expected 0 0 0 1", r_level, r_ovf, r_unf, r_rempty);
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({r_unf, f_unf, r_level} !== {1'b1, 1'b1, 5'd0}) begin
      errors++; $display("FAIL underflow: got unf %b%b level %0d expected 11 0", r_unf, f_unf, r_level);
    end
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    checks++;
    if ({r_level, f_level, r_rempty} !== {5'd1, 5'd1, 1'b0}) begin
      errors++; $display("FAIL push_pop_empty: got level %0d rempty %b expected 1 0", r_level, r_rempty);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    for (int i = 8; i < 48; i++) begin
      cyc(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
      checks++;
      if ({r_level, f_level} !== {5'd8, 5'd8}) begin
        errors++; $display("FAIL b2b_level cycle %0d: got %0d/%0d expected 8", i, r_level, f_level);
      end
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fwft();
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++;
    if ({f_rdata, f_rempty} !== {8'h3C, 1'b0}) begin
      errors++; $display("FAIL fwft_first: got rdata %h rempty %b expected 3c 0", f_rdata, f_rempty);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (r_rdata !== 8'h3C) begin
      errors++; $display("FAIL reg_first: got %h expected 3c", r_rdata);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    winc = 1'b1; wdata = 8'hE1;
    #2 rst_n = 1'b0;
    #1;
    q.delete(); reg_rd = 8'h00; mdl_ovf = 1'b0; mdl_unf = 1'b0;
    checks++;
    if ({r_level, f_level, r_unf, r_rdata, r_rempty, r_arempty, f_rempty, r_wfull} !== {5'd0, 5'd0, 1'b0, 8'h00, 4'b1110}) begin
      errors++; $display("FAIL async_reset: got level %0d/%0d unf %b rdata %h flags %b%b%b%b expected 0 0 00 1110",
                         r_level, f_level, r_unf, r_rdata, r_rempty, r_arempty, f_rempty, r_wfull);
    end
    winc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    checks++;
    if ({f_rdata, r_level} !== {8'hC3, 5'd1}) begin
      errors++; $display("FAIL post_reset: got rdata %h level %0d expected c3 1", f_rdata, r_level);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
